// File: rtl/dec_nto2n_seq.sv
// dec_nto2n_seq: registered N-to-2^N one-hot decoder with a valid/ready input
// handshake and an auto-advancing walking-one scan mode.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         block enable; 0 returns the block to IDLE with y idle
//   mode       0 = decode, 1 = scan
//   in_valid   select word valid
//   in_ready   block can accept a select word (combinational)
//   i          select index, N bits
//   y          registered one-hot output, 2**N bits
//   out_valid  one-cycle pulse when y was loaded from an accepted select word
//   scan_wrap  one-cycle pulse when the scan wraps from the MSB to bit 0
//
// Build option: define DEC_ACTIVE_LOW_EN for one-cold output polarity
// (idle value all ones, a single walking/decoded zero).
module dec_nto2n_seq #(
  parameter int unsigned N        = 4,
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      i,
  output logic [(2**N)-1:0] y,
  output logic              out_valid,
  output logic              scan_wrap
);

  localparam int unsigned W     = 2 ** N;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [W-1:0] Y_IDLE = '1;
  localparam logic         Y_ACT  = 1'b0;
`else
  localparam logic [W-1:0] Y_IDLE = '0;
  localparam logic         Y_ACT  = 1'b1;
`endif

  // Active bit at position 0 in the selected polarity.
  localparam logic [W-1:0] Y_FIRST = Y_IDLE ^ W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     y_q, y_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             out_valid_q, out_valid_d;
  logic             scan_wrap_q, scan_wrap_d;

  // Ready drops in the same cycle as en, mode or reset change.
  assign in_ready = rst_n && en && !mode && (state_q == ST_DECODE);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    div_d       = div_q;
    out_valid_d = 1'b0;
    scan_wrap_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      y_d     = Y_IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          y_d = Y_IDLE;
          if (mode) begin
            state_d = ST_SCAN;
            y_d     = Y_FIRST;
            div_d   = DIV_LOAD;
          end else begin
            state_d = ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (mode) begin
            state_d = ST_SCAN;
            y_d     = Y_FIRST;
            div_d   = DIV_LOAD;
          end else if (in_valid && in_ready) begin
            y_d         = Y_IDLE ^ (W'(1) << i);
            out_valid_d = 1'b1;
          end
        end

        ST_SCAN: begin
          if (!mode) begin
            state_d = ST_DECODE;
            y_d     = Y_IDLE;
            div_d   = '0;
          end else if (div_q == '0) begin
            // Rotate left; the bit leaving the MSB re-enters at bit 0.
            y_d         = {y_q[W-2:0], y_q[W-1]};
            div_d       = DIV_LOAD;
            scan_wrap_d = (y_q[W-1] == Y_ACT);
          end else begin
            div_d = div_q - DIV_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          y_d     = Y_IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_q         <= Y_IDLE;
      div_q       <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      div_q       <= div_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign scan_wrap = scan_wrap_q;

  // y is idle or carries exactly one active bit.
`ifdef DEC_ACTIVE_LOW_EN
  a_one_active: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~y_q));
`else
  a_one_active: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_q));
`endif

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// Testbench for dec_nto2n_seq: a behavioural model predicts y, scan_wrap and
// in_ready each cycle; accepted select words push their expected y into a
// scoreboard queue that a separate monitor drains on every out_valid pulse.
module tb_dec_nto2n_seq;

  localparam int unsigned N        = 4;
  localparam int unsigned SCAN_DIV = 2;
  localparam int unsigned W        = 2 ** N;

  localparam int M_IDLE = 0;
  localparam int M_DEC  = 1;
  localparam int M_SCAN = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] i = '0;
  logic [W-1:0] y;
  logic         out_valid;
  logic         scan_wrap;

  dec_nto2n_seq #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .y         (y),
    .out_valid (out_valid),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: what the outputs hold after the most recent edge.
  int           mst   = M_IDLE;
  int           scnt  = 0;
  logic [W-1:0] my    = '0;
  logic         mwrap = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pol(input logic [W-1:0] x);
`ifdef DEC_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the effect of the coming rising edge from the inputs just applied.
  task automatic model_step(input logic r, input logic e, input logic m,
                            input logic v, input logic [N-1:0] sel);
    mwrap = 1'b0;
    if (!r || !e) begin
      mst = M_IDLE;
      my  = '0;
    end else if (m && mst != M_SCAN) begin
      mst  = M_SCAN;
      scnt = 0;
      my   = W'(1);
    end else if (!m && mst != M_DEC) begin
      mst = M_DEC;
      my  = '0;
    end else if (mst == M_DEC) begin
      if (v) begin
        my = W'(1) << sel;
        exp_q.push_back(pol(my));
      end
    end else begin
      // Scan: position advances once every SCAN_DIV cycles since entry.
      scnt++;
      my    = W'(1) << ((scnt / SCAN_DIV) % W);
      mwrap = (scnt % (SCAN_DIV * W)) == 0;
    end
  endtask

  // One clock of stimulus: check registered outputs, drive, check in_ready.
  task automatic cycle(input logic r, input logic e, input logic m,
                       input logic v, input logic [N-1:0] sel);
    logic exp_rdy;
    @(negedge clk);
    chk("y", y, pol(my));
    chk("scan_wrap", W'(scan_wrap), W'(mwrap));
    rst_n    = r;
    en       = e;
    mode     = m;
    in_valid = v;
    i        = sel;
    #1;
    exp_rdy = r && e && !m && (mst == M_DEC);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    model_step(r, e, m, v, sel);
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest accept.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_valid_spurious: got y=%h with no accept pending", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            fails++;
            $display("FAIL out_valid_y: got %h expected %h at %0t", y, e, $time);
          end
        end
      end
    end
  end

  initial begin
    int           n;
    logic         rm;
    logic [N-1:0] s;

    // Reset held three clocks with en high.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1, N'(k));
    // Release: IDLE for one cycle, then DECODE.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Full back-to-back decode sweep, then hold.
    for (int k = 0; k < W; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1, N'(k));
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, N'($urandom));

    // Random decode traffic.
    for (int k = 0; k < 40; k++)
      cycle(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), N'($urandom));

    // Scan through two full wraps; in_valid is ignored.
    for (int k = 0; k < 2 * SCAN_DIV * W + 4; k++)
      cycle(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), N'($urandom));

    // Continue scanning until bit 5 is active, then switch to decode.
    n = 0;
    while (my != W'(16'h0020) && n < 200) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      n++;
    end
    chk("scan_reach_bit5", W'(n < 200), W'(1));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, N'(9));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // DECODE->SCAN with a pending handshake: not accepted.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, N'(7));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Back to decode, then drop en with a pending handshake.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, N'(3));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, N'(5));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, N'(5));

    // Reset in the middle of a scan.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, '0);

    // Mixed random traffic with occasional en drops, mode flips and resets.
    rm = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      s = N'($urandom);
      cycle(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 14) != 0), rm,
            1'($urandom_range(0, 2) != 0), s);
    end

    // Drain and confirm every accept produced its out_valid.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("scoreboard_drained", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
